dmem_stage: RTL and testbench

- Memory-stage responder for the RV32I pipeline. It consumes the EX_ME request fields: mem_r, mem_w, mem_addr, mem_data, reg_w, reg_data, and rd/funct3 carried alongside.
- It owns the data RAM and services byte, half and word loads and stores.
- It presents a registered ME_WB result (write enable, destination, data) to the writeback stage.
- It is the target end of the load/store interface that exec initiates.

---
 rtl/dmem_stage_pkg.sv | 13 +
 rtl/dmem_ram.sv | 28 ++
 rtl/dmem_stage.sv | 154 +++++++++++++++
 tb/tb_dmem_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_stage_pkg.sv
// Shared definitions for the memory stage: data width and funct3 access encodings.
package dmem_stage_pkg;

  localparam int XLEN = 32;

  // funct3 encodings shared by loads and stores (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_ram.sv
// Byte-enabled single-port data RAM with registered read.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // per-lane write; untouched lanes keep their contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // registered read, only refreshed when a load asks for it
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_stage.sv
// Memory stage: legality check, store lane steering, load extension and ME_WB register.
module dmem_stage
  import dmem_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_r,
  input  logic            mem_w,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            reg_w,
  input  logic [XLEN-1:0] reg_data,
  input  logic [4:0]      rd,
  output logic            wb_reg_w,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign,
  output logic            misalign_sticky
);

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              unused_addr_hi;

  logic              aligned;
  logic              f3_load_ok;
  logic              f3_store_ok;
  logic              illegal;

  logic [3:0]        ram_we;
  logic              ram_re;
  logic [XLEN-1:0]   ram_wdata;
  logic [XLEN-1:0]   ram_rdata;

  logic              load_q;
  logic [2:0]        ld_f3_q;
  logic [1:0]        ld_lane_q;
  logic [XLEN-1:0]   alu_q;
  logic [XLEN-1:0]   ld_ext;

  // upper address bits fold away so addresses wrap over the RAM size
  assign word_idx       = mem_addr[ADDR_W+1:2];
  assign lane           = mem_addr[1:0];
  assign unused_addr_hi = ^mem_addr[XLEN-1:ADDR_W+2];

  // legality: funct3 must suit the access, address must suit the size, never both r and w
  always_comb begin
    aligned     = 1'b1;
    f3_load_ok  = 1'b0;
    f3_store_ok = 1'b0;
    illegal     = 1'b0;
    case (funct3)
      F3_H, F3_HU: aligned = ~lane[0];
      F3_W:        aligned = (lane == 2'b00);
      default:     aligned = 1'b1;
    endcase
    case (funct3)
      F3_B, F3_H, F3_W: begin
        f3_load_ok  = 1'b1;
        f3_store_ok = 1'b1;
      end
      F3_BU, F3_HU: f3_load_ok = 1'b1;
      default: ;
    endcase
    if (mem_r && mem_w)
      illegal = 1'b1;
    else if (mem_r)
      illegal = ~f3_load_ok | ~aligned;
    else if (mem_w)
      illegal = ~f3_store_ok | ~aligned;
  end

  // store steering: replicate data across lanes and enable only the addressed ones
  always_comb begin
    ram_we    = 4'b0000;
    ram_wdata = mem_data;
    if (mem_w && !illegal && !reset) begin
      case (funct3)
        F3_B: begin
          ram_we    = 4'b0001 << lane;
          ram_wdata = {4{mem_data[7:0]}};
        end
        F3_H: begin
          ram_we    = lane[1] ? 4'b1100 : 4'b0011;
          ram_wdata = {2{mem_data[15:0]}};
        end
        F3_W: ram_we = 4'b1111;
        default: ram_we = 4'b0000;
      endcase
    end
  end

  assign ram_re = mem_r & ~illegal & ~reset;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (word_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ME_WB register; the RAM output register holds the load word itself
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_reg_w        <= 1'b0;
      wb_rd           <= '0;
      alu_q           <= '0;
      load_q          <= 1'b0;
      ld_f3_q         <= '0;
      ld_lane_q       <= '0;
      misalign        <= 1'b0;
      misalign_sticky <= 1'b0;
    end else begin
      wb_reg_w        <= reg_w & ~illegal;
      wb_rd           <= rd;
      alu_q           <= mem_r ? '0 : reg_data;
      load_q          <= mem_r & ~illegal;
      ld_f3_q         <= funct3;
      ld_lane_q       <= lane;
      misalign        <= illegal;
      misalign_sticky <= misalign_sticky | illegal;
    end
  end

  // select the addressed byte/half of the registered word and extend it
  always_comb begin
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    ld_byte = ram_rdata[{ld_lane_q, 3'b000} +: 8];
    ld_half = ld_lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (ld_f3_q)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_ext = {24'd0, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_ext = {16'd0, ld_half};
      default: ld_ext = ram_rdata;
    endcase
  end

  // final writeback mux: load result or the ALU value carried through
  always_comb begin
    wb_data = load_q ? ld_ext : alu_q;
  end

endmodule

// File: tb/tb_dmem_stage.sv
// Self-checking bench for dmem_stage: directed scenarios plus randomized traffic
// compared against a byte-array memory model.
module tb_dmem_stage;

  localparam int DEPTH_WORDS = 1024;
  localparam int ADDR_W      = 10;
  localparam int NBYTES      = DEPTH_WORDS * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_r, mem_w;
  logic [2:0]  funct3;
  logic [31:0] mem_addr, mem_data;
  logic        reg_w;
  logic [31:0] reg_data;
  logic [4:0]  rd;
  logic        wb_reg_w;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign, misalign_sticky;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [NBYTES];
  logic        exp_reg_w;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        exp_mis;
  logic        exp_sticky;

  dmem_stage #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_r           (mem_r),
    .mem_w           (mem_w),
    .funct3          (funct3),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .reg_w           (reg_w),
    .reg_data        (reg_data),
    .rd              (rd),
    .wb_reg_w        (wb_reg_w),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .misalign        (misalign),
    .misalign_sticky (misalign_sticky)
  );

  always #5 clk = ~clk;

  function automatic bit model_illegal(input bit r, input bit w, input logic [2:0] f3,
                                       input logic [31:0] a);
    bit f3_ok;
    int size;
    if (r && w) return 1'b1;
    if (!r && !w) return 1'b0;
    if (r) f3_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    else   f3_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    if (!f3_ok) return 1'b1;
    size = 1 << f3[1:0];
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int size, base;
    size = 1 << f3[1:0];
    base = int'(a % NBYTES);
    v = 32'd0;
    for (int k = 0; k < size; k++) v = v | (32'(model_mem[base + k]) << (8 * k));
    if (!f3[2] && size < 4 && v[8*size-1]) v = v - (32'd1 << (8 * size));
    return v;
  endfunction

  // drive one request at the falling edge, predict its result, advance to the next falling edge
  task automatic step(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input bit rw, input logic [31:0] rdat,
                      input logic [4:0] rdd, input bit rst);
    bit ill;
    int size, base;
    reset = rst; mem_r = r; mem_w = w; funct3 = f3; mem_addr = a; mem_data = d;
    reg_w = rw; reg_data = rdat; rd = rdd;
    if (rst) begin
      exp_reg_w = 0; exp_rd = 0; exp_data = 0; exp_mis = 0; exp_sticky = 0;
    end else begin
      ill = model_illegal(r, w, f3, a);
      exp_reg_w  = rw && !ill;
      exp_rd     = rdd;
      exp_data   = r ? (ill ? 32'd0 : model_load(f3, a)) : rdat;
      exp_mis    = ill;
      exp_sticky = exp_sticky | ill;
      if (w && !ill) begin
        size = 1 << f3[1:0];
        base = int'(a % NBYTES);
        for (int k = 0; k < size; k++) model_mem[base + k] = 8'((d >> (8 * k)) & 32'hFF);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(0, 0, 3'd0, 32'h0, 32'h0, 1, 32'h1234, 5'd9, 1);
    step(0, 0, 3'd0, 32'h0, 32'h0, 1, 32'h1234, 5'd9, 1);
    checks++;
    if ({wb_reg_w, wb_rd, wb_data, misalign, misalign_sticky} !== 40'd0) begin
      errors++;
      $display("FAIL reset_state: got reg_w=%0b rd=%0d data=%h mis=%0b sticky=%0b, want all zero",
               wb_reg_w, wb_rd, wb_data, misalign, misalign_sticky);
    end
  endtask

  task automatic test_word();
    step(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0, 5'd0, 0);
    step(1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h0, 5'd5, 0);
    checks++;
    if (wb_reg_w !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEADBEEF || misalign !== 1'b0) begin
      errors++;
      $display("FAIL sw_lw: got reg_w=%0b rd=%0d data=%h mis=%0b, want 1 5 deadbeef 0",
               wb_reg_w, wb_rd, wb_data, misalign);
    end
  endtask

  task automatic test_subword();
    logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] adr [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exv [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      step(1, 0, f3s[i], adr[i], 32'h0, 1, 32'h0, 5'd6, 0);
      checks++;
      if (wb_data !== exv[i] || wb_reg_w !== 1'b1) begin
        errors++;
        $display("FAIL subword_load%0d: got data=%h reg_w=%0b, want %h 1", i, wb_data, wb_reg_w, exv[i]);
      end
    end
    step(0, 1, 3'd0, 32'h11, 32'h000000AA, 0, 32'h0, 5'd0, 0);
    step(1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h0, 5'd7, 0);
    checks++;
    if (wb_data !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL sb_merge: got %h want deadaaef", wb_data);
    end
    step(0, 1, 3'd1, 32'h12, 32'h00001234, 0, 32'h0, 5'd0, 0);
    step(1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h0, 5'd7, 0);
    checks++;
    if (wb_data !== 32'h1234AAEF) begin
      errors++;
      $display("FAIL sh_merge: got %h want 1234aaef", wb_data);
    end
  endtask

  task automatic test_misalign();
    step(1, 0, 3'd2, 32'h0000_1012, 32'h0, 1, 32'h0, 5'd4, 0);
    checks++;
    if (misalign !== 1'b1 || wb_reg_w !== 1'b0 || wb_data !== 32'd0 || misalign_sticky !== 1'b1) begin
      errors++;
      $display("FAIL misalign_lw: got mis=%0b reg_w=%0b data=%h sticky=%0b, want 1 0 0 1",
               misalign, wb_reg_w, wb_data, misalign_sticky);
    end
    step(0, 1, 3'd2, 32'h14, 32'h600DF00D, 0, 32'h0, 5'd0, 0);
    checks++;
    if (misalign !== 1'b0 || misalign_sticky !== 1'b1) begin
      errors++;
      $display("FAIL misalign_pulse: got mis=%0b sticky=%0b, want 0 1", misalign, misalign_sticky);
    end
    step(1, 0, 3'd2, 32'h14, 32'h0, 1, 32'h0, 5'd8, 0);
    checks++;
    if (wb_data !== 32'h600DF00D || wb_reg_w !== 1'b1 || misalign_sticky !== 1'b1) begin
      errors++;
      $display("FAIL after_misalign: got data=%h reg_w=%0b sticky=%0b, want 600df00d 1 1",
               wb_data, wb_reg_w, misalign_sticky);
    end
  endtask

  task automatic test_wrap();
    step(0, 1, 3'd2, 32'h1000, 32'h00000055, 0, 32'h0, 5'd0, 0);
    step(1, 0, 3'd2, 32'h0, 32'h0, 1, 32'h0, 5'd2, 0);
    checks++;
    if (wb_data !== 32'h00000055) begin
      errors++;
      $display("FAIL wrap: got %h want 00000055", wb_data);
    end
  endtask

  task automatic test_alu_and_reset();
    step(0, 0, 3'd7, 32'hFFFF_FFFF, 32'h0, 1, 32'h7, 5'd3, 0);
    checks++;
    if (wb_data !== 32'h7 || wb_rd !== 5'd3 || wb_reg_w !== 1'b1 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL alu_pass: got data=%h rd=%0d reg_w=%0b mis=%0b, want 7 3 1 0",
               wb_data, wb_rd, wb_reg_w, misalign);
    end
    step(1, 0, 3'd2, 32'h14, 32'h0, 1, 32'h0, 5'd7, 1);
    checks++;
    if ({wb_reg_w, wb_rd, wb_data, misalign, misalign_sticky} !== 40'd0) begin
      errors++;
      $display("FAIL reset_load: got reg_w=%0b rd=%0d data=%h mis=%0b sticky=%0b, want all zero",
               wb_reg_w, wb_rd, wb_data, misalign, misalign_sticky);
    end
    step(0, 1, 3'd2, 32'h14, 32'hCAFEF00D, 0, 32'h0, 5'd0, 1);
    step(1, 0, 3'd2, 32'h14, 32'h0, 1, 32'h0, 5'd9, 0);
    checks++;
    if (wb_data !== 32'h600DF00D || wb_rd !== 5'd9) begin
      errors++;
      $display("FAIL reset_store_dropped: got data=%h rd=%0d, want 600df00d 9", wb_data, wb_rd);
    end
  endtask

  task automatic test_random();
    bit r, w;
    int op;
    logic [31:0] a;
    for (int i = 0; i < 16; i++)
      step(0, 1, 3'd2, 32'(i * 4), $urandom(), 0, 32'h0, 5'd0, 0);
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      r  = (op <= 3) || (op == 9);
      w  = (op >= 4 && op <= 7) || (op == 9);
      a  = 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 15)) << 12);
      step(r, w, 3'($urandom_range(0, 7)), a, $urandom(), 1'($urandom_range(0, 1)),
           $urandom(), 5'($urandom_range(0, 31)), 0);
      checks++;
      if (wb_reg_w !== exp_reg_w || wb_rd !== exp_rd || wb_data !== exp_data ||
          misalign !== exp_mis || misalign_sticky !== exp_sticky) begin
        errors++;
        $display("FAIL random%0d: got reg_w=%0b rd=%0d data=%h mis=%0b sticky=%0b, want %0b %0d %h %0b %0b",
                 n, wb_reg_w, wb_rd, wb_data, misalign, misalign_sticky,
                 exp_reg_w, exp_rd, exp_data, exp_mis, exp_sticky);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;
    exp_sticky = 0;
    reset = 1; mem_r = 0; mem_w = 0; funct3 = 0; mem_addr = 0; mem_data = 0;
    reg_w = 0; reg_data = 0; rd = 0;
    @(negedge clk);
    test_reset();
    test_word();
    test_subword();
    test_misalign();
    test_wrap();
    test_alu_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
